// File: rtl/seg7_scan_driver_if.sv
// CPU-side bus of the seven-segment scan driver: display data, decimal
// points, digit enables, the load strobe and the frame-commit pulse.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   data_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     en_in;
    logic                  frame_done;

    modport master (
        output load,
        output data_in,
        output dp_in,
        output en_in,
        input  frame_done
    );

    modport slave (
        input  load,
        input  data_in,
        input  dp_in,
        input  en_in,
        output frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. Scans one digit per
// slot with a blanking gap at the start of each slot. New data is
// committed to the display only at frame boundaries.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BLANK | start of slot, all anodes off (cnt < BLANK_CYC)
//   ST_SHOW  | current digit lit if enabled (BLANK_CYC <= cnt < SCAN_DIV)
module seg7_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    bus,
    output logic [DIGITS-1:0]    an,
    output logic [6:0]           seg,
    output logic                 dp
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [DIG_W-1:0] DIG_LAST       = DIG_W'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } phase_t;

    phase_t               r_phase;
    phase_t               w_phase_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [DIG_W-1:0]     r_dig;
    logic [DIG_W-1:0]     w_dig_nxt;
    logic                 w_slot_end;
    logic                 w_commit;

    logic [4*DIGITS-1:0]  r_data_shd;
    logic [DIGITS-1:0]    r_dp_shd;
    logic [DIGITS-1:0]    r_en_shd;
    logic                 r_pending;

    logic [4*DIGITS-1:0]  r_data_act;
    logic [DIGITS-1:0]    r_dp_act;
    logic [DIGITS-1:0]    r_en_act;

    logic [3:0]           w_nib;
    logic [DIGITS-1:0]    w_an;
    logic [6:0]           w_seg;
    logic                 w_dp;

    logic [DIGITS-1:0]    r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic                 r_frame_done;

    // Hex to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] f_decode(input logic [3:0] i_nib);
        logic [6:0] v;
        case (i_nib)
            4'h0:    v = 7'h40;
            4'h1:    v = 7'h79;
            4'h2:    v = 7'h24;
            4'h3:    v = 7'h30;
            4'h4:    v = 7'h19;
            4'h5:    v = 7'h12;
            4'h6:    v = 7'h02;
            4'h7:    v = 7'h78;
            4'h8:    v = 7'h00;
            4'h9:    v = 7'h10;
            4'hA:    v = 7'h08;
            4'hB:    v = 7'h03;
            4'hC:    v = 7'h46;
            4'hD:    v = 7'h21;
            4'hE:    v = 7'h06;
            default: v = 7'h0E;
        endcase
        return v;
    endfunction

    // Phase, slot counter and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= ST_BLANK;
            r_cnt   <= '0;
            r_dig   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dig   <= w_dig_nxt;
        end
    end

    // Next phase, counter and digit; the digit advances on the slot wrap.
    always_comb begin
        w_phase_nxt = r_phase;
        w_slot_end  = (r_cnt == CNT_LAST);
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_dig_nxt   = r_dig;
        if (w_slot_end) begin
            w_cnt_nxt = '0;
            w_dig_nxt = (r_dig == DIG_LAST) ? '0 : r_dig + DIG_W'(1);
        end
        case (r_phase)
            ST_BLANK: begin
                if (r_cnt == CNT_BLANK_LAST) begin
                    w_phase_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_slot_end) begin
                    w_phase_nxt = ST_BLANK;
                end
            end
            default: w_phase_nxt = ST_BLANK;
        endcase
    end

    // Commit happens on the last cycle of the last slot when new data waits,
    // or when a load lands exactly on that cycle.
    assign w_commit = w_slot_end && (r_dig == DIG_LAST) && (r_pending || bus.load);

    // Shadow capture and pending flag; a later load simply overwrites.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_shd <= '0;
            r_dp_shd   <= '0;
            r_en_shd   <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (bus.load) begin
                r_data_shd <= bus.data_in;
                r_dp_shd   <= bus.dp_in;
                r_en_shd   <= bus.en_in;
            end
            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Active display data, updated only at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_act <= '0;
            r_dp_act   <= '0;
            r_en_act   <= '0;
        end else if (w_commit) begin
            if (bus.load) begin
                r_data_act <= bus.data_in;
                r_dp_act   <= bus.dp_in;
                r_en_act   <= bus.en_in;
            end else begin
                r_data_act <= r_data_shd;
                r_dp_act   <= r_dp_shd;
                r_en_act   <= r_en_shd;
            end
        end
    end

    // Display pattern for the current phase and digit; blank unless lit.
    always_comb begin
        w_nib = r_data_act[{r_dig, 2'b00} +: 4];
        w_an  = '1;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (r_phase == ST_SHOW && r_en_act[r_dig]) begin
            w_an  = ~(DIGITS'(1) << r_dig);
            w_seg = f_decode(w_nib);
            w_dp  = ~r_dp_act[r_dig];
        end
    end

    // Registered outputs: one cycle behind the scan state, glitch-free pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_done <= w_commit;
        end
    end

    assign an             = r_an;
    assign seg            = r_seg;
    assign dp             = r_dp;
    assign bus.frame_done = r_frame_done;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's common-anode seven-segment display bank. It accepts hex nibbles, decimal-point flags and per-digit enables from the CPU's MMIO output register. It scans one digit at a time with an inter-digit blanking gap to suppress ghosting. New display data is committed only at frame boundaries, so the display never shows a torn value. It sits on the output side of the board I/O path, opposite the debounced switch/button inputs.

## Interface
- DIGITS, 8: number of digits scanned, 1..8
- SCAN_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be >= 2
- BLANK_CYC, 1000: cycles at the start of each slot with all anodes off; 1 <= BLANK_CYC < SCAN_DIV
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  single-cycle strobe: capture data_in, dp_in, en_in into the shadow registers
- data_in  in  4*DIGITS  hex nibbles; nibble i drives digit i
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- en_in  in  DIGITS  digit enable, 1 = digit displayed
- an  out  DIGITS  anode selects, active-low, at most one low at any time
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse when the frame-boundary commit occurs

## Operation
- Internal state: slot counter cnt (0..SCAN_DIV-1), digit index dig (0..DIGITS-1), phase FSM {BLANK, SHOW}, shadow registers, active registers, pending flag.
- FSM transitions:
  - BLANK while cnt < BLANK_CYC.
  - BLANK -> SHOW when cnt reaches BLANK_CYC.
  - SHOW -> BLANK when cnt wraps from SCAN_DIV-1 to 0. dig increments at the same edge and wraps DIGITS-1 -> 0.
- BLANK phase: an = all 1, seg = 7'h7F, dp = 1.
- SHOW phase, en_active[dig] = 1:
  - an[dig] = 0, all other anode bits = 1.
  - seg = decode(nibble dig), using 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
  - dp = ~dp_active[dig].
- SHOW phase, en_active[dig] = 0: outputs as in BLANK. The slot is still consumed, so brightness stays uniform across frames.
- load = 1: shadow <= inputs, pending <= 1. A later load before the commit overwrites the shadow; the last one wins.
- Frame-boundary commit occurs on the edge where dig = DIGITS-1 and cnt = SCAN_DIV-1:
  - If pending or load: active <= (load ? inputs : shadow), pending <= 0, frame_done pulses.
  - Otherwise there is no commit and frame_done stays 0.
- A load in the commit cycle is applied immediately; it bypasses the shadow.

## Timing
- Reset values (asynchronous):
  - an = all 1, seg = 7'h7F, dp = 1, frame_done = 0.
  - cnt = 0, dig = 0, phase = BLANK.
  - shadow and active registers all 0 (display blank); pending = 0.
- an, seg, dp and frame_done are registered. They reflect the cnt/dig/phase of the previous cycle, a fixed 1-cycle lag.
- Slot = SCAN_DIV cycles; frame = DIGITS*SCAN_DIV cycles.
- Lit period per slot = SCAN_DIV - BLANK_CYC cycles.
- Anodes of two digits are never simultaneously low, including across slot boundaries: a BLANK of at least 1 cycle always separates them.
- Load-to-display latency: from the load edge, new data appears no earlier than the first SHOW of digit 0 in the next frame, and no later than 1 frame + BLANK_CYC + 1 cycles.
- rst_n asserted mid-slot: outputs blank immediately, with no wait for the clock. Scanning restarts at digit 0, cnt 0 on the first edge after release. Pending shadow data is discarded.

## Test plan
Parameters for all scenarios: DIGITS=4, SCAN_DIV=10, BLANK_CYC=2.
- Reset then idle for 80 cycles -> an stays 4'hF and seg 7'h7F throughout; frame_done never pulses.
- load with data_in=16'h3A10, en_in=4'hF, dp_in=4'b0010 -> after commit (frame_done pulse), per slot: 2 cycles blank, then 8 cycles with:
  - an=4'hE, seg=7'h40, dp=1 (digit 0 shows 0);
  - an=4'hD, seg=7'h79, dp=0 (digit 1 shows 1 with point lit);
  - an=4'hB, seg=7'h08 (digit 2 shows A);
  - an=4'h7, seg=7'h30 (digit 3 shows 3).
- en_in=4'b0101 -> digits 1 and 3 stay dark for their full 10-cycle slots; frame period remains 40 cycles.
- Mid-frame load of 16'hFFFF followed by load of 16'h1234 before the boundary -> the current frame is unchanged; the next frame shows 1234; exactly one frame_done pulse occurs.
- load asserted exactly in the commit cycle -> that data is shown in the very next frame, and frame_done pulses in the same cycle-after.
- rst_n pulsed low while digit 2 is lit -> an=4'hF asynchronously; after release, digit 0 is the first lit, after 1+2 cycles, with the active data cleared (blank).
